// File: rtl/rp_8bit_io_master.sv
// rp_8bit_io_master: I/O bus initiator for the rp_8bit core.
// Accepts one IN/OUT/SBI/CBI/SBIS/SBIC request at a time and turns it into
// per-register read/write strobes for up to NP three-register peripheral slots.
// Read-modify-write (SBI/CBI) and bit-test (SBIS/SBIC) are sequenced here.
module rp_8bit_io_master #(
  parameter int          NP   = 4,
  parameter logic [5:0]  BASE = 6'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [2:0]        req_op,
  input  logic [5:0]        req_adr,
  input  logic [7:0]        req_dat,
  input  logic [2:0]        req_bit,
  output logic              rsp_vld,
  output logic [7:0]        rsp_dat,
  output logic              rsp_skip,
  output logic [3*NP-1:0]   io_re,
  output logic [3*NP-1:0]   io_we,
  output logic [7:0]        io_dw,
  input  logic [8*NP-1:0]   io_dr
);

  localparam int NR = 3 * NP;
  localparam int SW = (NP > 1) ? $clog2(NP) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  localparam logic [2:0] OP_IN   = 3'd0;
  localparam logic [2:0] OP_OUT  = 3'd1;
  localparam logic [2:0] OP_SBI  = 3'd2;
  localparam logic [2:0] OP_CBI  = 3'd3;
  localparam logic [2:0] OP_SBIS = 3'd4;
  localparam logic [2:0] OP_SBIC = 3'd5;

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [7:0]    dat_q, dat_d;
  logic [2:0]    bit_q, bit_d;
  logic          mapped_q, mapped_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    k_q, k_d;
  logic [7:0]    rdat_q, rdat_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic          rsp_skip_q, rsp_skip_d;

  logic [6:0]    dec_off;
  logic          dec_mapped;
  logic [SW-1:0] dec_slot;
  logic [1:0]    dec_k;
  logic [7:0]    rd_byte;
  logic [7:0]    bit_mask;
  logic [7:0]    wdat;
  logic          accept;

  assign req_rdy  = (state_q == ST_IDLE);
  assign rsp_vld  = (state_q == ST_RSP);
  assign rsp_dat  = rsp_dat_q;
  assign rsp_skip = rsp_skip_q;
  assign accept   = req_vld & req_rdy;

  // Decode the incoming address into slot/offset; only used at accept time.
  always_comb begin
    dec_off    = {1'b0, req_adr} - {1'b0, BASE};
    dec_mapped = (req_adr >= BASE) && (dec_off < 7'(NR));
    dec_slot   = SW'(dec_off / 7'd3);
    dec_k      = 2'(dec_off % 7'd3);
  end

  // Strobes come straight from state and the registered decode, so a reset
  // removes them in the same cycle without waiting for a clock edge.
  always_comb begin
    io_re = '0;
    io_we = '0;
    for (int s = 0; s < NP; s++) begin
      for (int k = 0; k < 3; k++) begin
        if (mapped_q && (slot_q == SW'(s)) && (k_q == 2'(k))) begin
          io_re[3*s+k] = (state_q == ST_RD);
          io_we[3*s+k] = (state_q == ST_WR);
        end
      end
    end
  end

  // Select the strobed slot's read byte; unmapped reads see zero.
  always_comb begin
    rd_byte = 8'h00;
    for (int s = 0; s < NP; s++) begin
      if (mapped_q && (slot_q == SW'(s))) begin
        rd_byte = io_dr[8*s +: 8];
      end
    end
  end

  // Write data: OUT passes the request byte, SBI/CBI modify the byte just read.
  always_comb begin
    bit_mask = 8'd1 << bit_q;
    case (op_q)
      OP_SBI:  wdat = rdat_q | bit_mask;
      OP_CBI:  wdat = rdat_q & ~bit_mask;
      default: wdat = dat_q;
    endcase
    io_dw = (state_q == ST_WR) ? wdat : 8'h00;
  end

  // Sequencer: next state, request capture, read capture and response data.
  // The response registers are loaded on the edge that enters RSP so they are
  // already valid while rsp_vld is high, and they hold until the next RSP.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dat_d      = dat_q;
    bit_d      = bit_q;
    mapped_d   = mapped_q;
    slot_d     = slot_q;
    k_d        = k_q;
    rdat_d     = rdat_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_skip_d = rsp_skip_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = req_op;
          dat_d    = req_dat;
          bit_d    = req_bit;
          mapped_d = dec_mapped;
          slot_d   = dec_slot;
          k_d      = dec_k;
          case (req_op)
            OP_IN, OP_SBI, OP_CBI, OP_SBIS, OP_SBIC: state_d = ST_RD;
            OP_OUT:  state_d = ST_WR;
            default: begin
              state_d    = ST_RSP;
              rsp_dat_d  = 8'h00;
              rsp_skip_d = 1'b0;
            end
          endcase
        end
      end
      ST_RD: begin
        rdat_d = rd_byte;
        if ((op_q == OP_SBI) || (op_q == OP_CBI)) begin
          state_d = ST_WR;
        end else begin
          state_d    = ST_RSP;
          rsp_dat_d  = rd_byte;
          rsp_skip_d = 1'b0;
          if (op_q == OP_SBIS) rsp_skip_d = rd_byte[bit_q];
          if (op_q == OP_SBIC) rsp_skip_d = ~rd_byte[bit_q];
        end
      end
      ST_WR: begin
        state_d    = ST_RSP;
        rsp_dat_d  = wdat;
        rsp_skip_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a reset aborts
  // any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'd0;
      dat_q      <= 8'h00;
      bit_q      <= 3'd0;
      mapped_q   <= 1'b0;
      slot_q     <= '0;
      k_q        <= 2'd0;
      rdat_q     <= 8'h00;
      rsp_dat_q  <= 8'h00;
      rsp_skip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dat_q      <= dat_d;
      bit_q      <= bit_d;
      mapped_q   <= mapped_d;
      slot_q     <= slot_d;
      k_q        <= k_d;
      rdat_q     <= rdat_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_skip_q <= rsp_skip_d;
    end
  end

endmodule
